// File: rtl/mem_access_if.sv
// Bus bundle between the control unit, the access controller and the SRAM.
// slave  : seen by mem_access_ctrl
// master : seen by whatever drives the control-unit side and models the SRAM
interface mem_access_if;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned SRAM_AW = 20;

    logic                Mem_CE;
    logic                Mem_OE;
    logic                Mem_WE;
    logic [DATA_W-1:0]   ADDR;
    logic [DATA_W-1:0]   Data_from_CPU;
    logic [DATA_W-1:0]   Switches;
    logic [DATA_W-1:0]   Data_to_CPU;
    logic [DATA_W-1:0]   HEX_Data;
    logic                Ready;
    logic [SRAM_AW-1:0]  SRAM_ADDR;
    logic                SRAM_CE_N;
    logic                SRAM_OE_N;
    logic                SRAM_WE_N;
    logic [DATA_W-1:0]   SRAM_DQ_in;
    logic [DATA_W-1:0]   SRAM_DQ_out;
    logic                SRAM_DQ_oe;

    modport slave (
        input  Mem_CE, Mem_OE, Mem_WE, ADDR, Data_from_CPU, Switches, SRAM_DQ_in,
        output Data_to_CPU, HEX_Data, Ready, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N,
               SRAM_WE_N, SRAM_DQ_out, SRAM_DQ_oe
    );

    modport master (
        output Mem_CE, Mem_OE, Mem_WE, ADDR, Data_from_CPU, Switches, SRAM_DQ_in,
        input  Data_to_CPU, HEX_Data, Ready, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N,
               SRAM_WE_N, SRAM_DQ_out, SRAM_DQ_oe
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// SRAM access sequencer between the CPU control unit and an asynchronous SRAM.
// Reads: one strobe cycle to capture, data valid on the second strobe cycle.
// Writes: setup / one-cycle WE pulse / hold, address and data latched at entry.
// Optional feature: define MEM_ACCESS_MMIO_EN to map word address 16'hFFFF to
// the board switches (read) and the hex display register (write).
module mem_access_ctrl (
    input  logic        Clk,
    input  logic        Reset,
    mem_access_if.slave bus
);
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned SRAM_AW = 20;
    localparam int unsigned PAD_W   = SRAM_AW - DATA_W;
    localparam logic [DATA_W-1:0] MMIO_ADDR = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_HOLD  = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   hex_q, hex_d;
    logic                mmio_q, mmio_d;

    logic                mmio_hit_c;
    logic                ce_n_c, oe_n_c, we_n_c, dq_oe_c, ready_c;
    logic [DATA_W-1:0]   sram_word_c;

    // Address decode for the memory-mapped switch/display location
`ifdef MEM_ACCESS_MMIO_EN
    assign mmio_hit_c = (bus.ADDR == MMIO_ADDR);
`else
    assign mmio_hit_c = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            hex_q   <= '0;
            mmio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            hex_q   <= hex_d;
            mmio_q  <= mmio_d;
        end
    end

    // Next-state, register updates and SRAM strobes
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        hex_d   = hex_q;
        mmio_d  = mmio_q;
        ce_n_c  = 1'b1;
        oe_n_c  = 1'b1;
        we_n_c  = 1'b1;
        dq_oe_c = 1'b0;
        ready_c = 1'b0;

        case (state_q)
            IDLE: begin
                // Write wins when both strobes are low; read strobes stay off then
                if (!bus.Mem_CE) begin
                    if (!bus.Mem_WE) begin
                        state_d = WR_SETUP;
                        addr_d  = bus.ADDR;
                        wdata_d = bus.Data_from_CPU;
                        mmio_d  = mmio_hit_c;
                    end else if (!bus.Mem_OE) begin
                        state_d = RD_HOLD;
                        addr_d  = bus.ADDR;
                        mmio_d  = mmio_hit_c;
                        rdata_d = mmio_hit_c ? bus.Switches : bus.SRAM_DQ_in;
                        if (!mmio_hit_c) begin
                            ce_n_c = 1'b0;
                            oe_n_c = 1'b0;
                        end
                    end
                end
            end
            RD_HOLD: begin
                // Strobe release ends the read in the same cycle it is seen
                if (bus.Mem_OE || bus.Mem_CE) begin
                    state_d = IDLE;
                end else begin
                    ready_c = 1'b1;
                    if (!mmio_q) begin
                        ce_n_c = 1'b0;
                        oe_n_c = 1'b0;
                    end
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                if (!mmio_q) begin
                    ce_n_c  = 1'b0;
                    dq_oe_c = 1'b1;
                end
            end
            WR_PULSE: begin
                state_d = WR_HOLD;
                ready_c = 1'b1;
                if (!mmio_q) begin
                    ce_n_c  = 1'b0;
                    we_n_c  = 1'b0;
                    dq_oe_c = 1'b1;
                end
`ifdef MEM_ACCESS_MMIO_EN
                else begin
                    hex_d = wdata_q;
                end
`endif
            end
            WR_HOLD: begin
                if (!mmio_q) begin
                    ce_n_c  = 1'b0;
                    dq_oe_c = 1'b1;
                end
                if (bus.Mem_WE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Live address in IDLE (read strobes are combinational), latched otherwise
    assign sram_word_c = (state_q == IDLE) ? bus.ADDR : addr_q;

    // Output mapping onto the bus
    assign bus.SRAM_ADDR   = {PAD_W'(0), sram_word_c};
    assign bus.SRAM_CE_N   = ce_n_c;
    assign bus.SRAM_OE_N   = oe_n_c;
    assign bus.SRAM_WE_N   = we_n_c;
    assign bus.SRAM_DQ_oe  = dq_oe_c;
    assign bus.SRAM_DQ_out = wdata_q;
    assign bus.Ready       = ready_c;
    assign bus.Data_to_CPU = rdata_q;
    assign bus.HEX_Data    = hex_q;
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have port: Clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: Reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: Mem_CE  input  1  active-low chip enable from control unit.
REQ-004 SHALL have port: Mem_OE  input  1  active-low read strobe from control unit.
REQ-005 SHALL have port: Mem_WE  input  1  active-low write strobe from control unit.
REQ-006 SHALL have port: ADDR  input  16  word address (MAR).
REQ-007 SHALL have port: Data_from_CPU  input  16  write data (MDR).
REQ-008 SHALL have port: Switches  input  16  board switch value.
REQ-009 SHALL have port: Data_to_CPU  output  16  registered read data to MDR mux.
REQ-010 SHALL have port: HEX_Data  output  16  registered memory-mapped display value.
REQ-011 SHALL have port: SRAM_ADDR  output  20  SRAM address, {4'h0, ADDR}.
REQ-012 SHALL have ports: SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  output  1 each  active-low SRAM strobes.
REQ-013 SHALL have ports: SRAM_DQ_in  input  16; SRAM_DQ_out  output  16; SRAM_DQ_oe  output  1  (1 = drive bus).
REQ-014 SHALL have port: Ready  output  1  high while read data valid or write committed.
REQ-015 SHALL have parameter: none; timing fixed by REQ-019..REQ-023.

Function
REQ-016 SHALL implement states IDLE, RD_HOLD, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-017 SHALL ignore Mem_OE/Mem_WE (stay IDLE, all SRAM strobes high, SRAM_DQ_oe=0) while Mem_CE=1.
REQ-018 SHALL treat Mem_OE=0 and Mem_WE=0 in the same cycle as a write (write priority).
REQ-019 Read: in IDLE with Mem_OE=0, SHALL drive SRAM_CE_N=0, SRAM_OE_N=0 combinationally that cycle, capture SRAM_DQ_in into Data_to_CPU at the edge, go to RD_HOLD.
REQ-020 RD_HOLD SHALL keep SRAM_OE_N=0, Data_to_CPU stable, Ready=1; return to IDLE on first cycle Mem_OE=1; read data thus valid on 2nd strobe cycle.
REQ-021 Write: in IDLE with Mem_WE=0, go to WR_SETUP; WR_SETUP drives SRAM_DQ_oe=1, SRAM_DQ_out=Data_from_CPU, SRAM_CE_N=0, SRAM_WE_N=1.
REQ-022 WR_PULSE (one cycle) SHALL drive SRAM_WE_N=0, data still driven, Ready=1.
REQ-023 WR_HOLD SHALL drive SRAM_WE_N=1, SRAM_DQ_oe=1 (hold); go IDLE when Mem_WE=1, else remain.
REQ-024 SHALL register Data_from_CPU and ADDR at WR_SETUP entry; later input changes SHALL not alter the write.
REQ-025 SHALL not start a new access until strobe returns high (no back-to-back without IDLE cycle).
REQ-026 SHALL never assert SRAM_OE_N=0 and SRAM_DQ_oe=1 in the same cycle.

Reset
REQ-027 On Reset=1 at an edge SHALL enter IDLE; Data_to_CPU=16'h0000, HEX_Data=16'h0000, Ready=0.
REQ-028 Reset mid-access SHALL deassert all SRAM strobes and SRAM_DQ_oe the following cycle; an interrupted write is not guaranteed committed.

Configuration
REQ-029 Macro MEM_ACCESS_MMIO_EN defined: address 16'hFFFF SHALL bypass SRAM (all SRAM strobes high); read returns Switches into Data_to_CPU with same timing as REQ-019/020; write loads Data_from_CPU into HEX_Data at WR_PULSE.
REQ-030 Macro undefined: 16'hFFFF SHALL be an ordinary SRAM address; HEX_Data SHALL stay 16'h0000.

Verification
REQ-031 Read: SRAM_DQ_in=16'h1234, ADDR=16'h0010, Mem_OE low 2 cycles -> SRAM_OE_N low both cycles, Data_to_CPU=16'h1234 and Ready=1 in cycle 2, IDLE in cycle 3.
REQ-032 Write: ADDR=16'h0020, Data_from_CPU=16'hBEEF, Mem_WE low 2 cycles -> SRAM_WE_N high/low/high across WR_SETUP/WR_PULSE/WR_HOLD, SRAM_DQ_out=16'hBEEF with oe=1 all three.
REQ-033 MMIO (MEM_ACCESS_MMIO_EN): Switches=16'h00A5, read 16'hFFFF -> Data_to_CPU=16'h00A5, SRAM_OE_N stays 1; write 16'h4321 to 16'hFFFF -> HEX_Data=16'h4321, SRAM_WE_N stays 1.
REQ-034 Mem_OE=0 and Mem_WE=0 together, Data_from_CPU=16'h0F0F -> write sequence, SRAM_OE_N never 0.
REQ-035 Reset asserted during WR_PULSE -> next cycle IDLE, SRAM_WE_N=1, SRAM_DQ_oe=0, Data_to_CPU=16'h0000.
REQ-036 Mem_CE=1 with Mem_OE=0 for 3 cycles -> no SRAM strobe, Ready=0 throughout.
